vec_pipe_stage_em: RTL and testbench
====================================

Name: vec_pipe_stage_em

Overview:
Parametrised EX/MEM pipeline stage for the vector datapath. It carries per-lane ALU results, store data, a lane-enable mask and scalar control bits from Execute to Memory. It adds a valid/ready handshake backed by a 2-entry skid buffer, a synchronous flush, and control-bit gating, so Memory-stage stalls propagate without a combinational ready path.

Parameters:
LANES, 16, number of vector lanes
DW, 32, bits per lane
RAW, 4, destination register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset; asynchronous, active-high
FlushE  in  1  synchronous flush, clears both entries
ValidE  in  1  Execute presents a valid bundle
ReadyE  out  1  stage can accept a bundle this cycle
ALUResultE  in  LANES*DW  per-lane ALU result; lane i = bits [i*DW +: DW]
WriteDataE  in  LANES*DW  per-lane store data
LaneMaskE  in  LANES  per-lane enable
PCSrcE  in  1  branch-taken control
RegWriteE  in  1  register write control
MemtoRegE  in  1  writeback source select
MemWriteE  in  1  memory write control
WA3E  in  RAW  destination register
ValidM  out  1  output bundle valid
ReadyM  in  1  Memory stage accepts the output bundle
ALUResultM  out  LANES*DW  registered ALUResultE
WriteDataM  out  LANES*DW  registered WriteDataE
LaneMaskM  out  LANES  registered LaneMaskE
PCSrcM  out  1  gated control, see Behaviour
RegWriteM  out  1  gated control, see Behaviour
MemtoRegM  out  1  gated control, see Behaviour
MemWriteM  out  1  gated control, see Behaviour
WA3M  out  RAW  registered WA3E
Occupancy  out  2  number of held entries (0..2)

Behaviour:
- Storage
  - Output register OUT drives the M ports.
  - Skid register SKD has the same contents as OUT.
- Handshake events
  - accept = ValidE & ReadyE.
  - drain = ValidM & ReadyM.
- State machine: EMPTY (Occupancy 0), ONE (1), FULL (2)
  - EMPTY: accept → OUT ← input, go to ONE. Otherwise hold.
  - ONE, accept & drain: OUT ← input, stay in ONE.
  - ONE, accept & !drain: SKD ← input, go to FULL.
  - ONE, !accept & drain: go to EMPTY. Otherwise hold.
  - FULL: drain → OUT ← SKD, go to ONE. Otherwise hold.
  - FULL: accept cannot occur because ReadyE = 0.
- Status outputs
  - ReadyE = (state != FULL). It depends only on registered state; there is no path from ReadyM to ReadyE.
  - ValidM = (state != EMPTY).
- Ordering and throughput
  - Strict FIFO order.
  - Latency is 1 cycle from accept to ValidM when OUT is free or draining.
  - Sustained throughput is 1 bundle/cycle while ReadyM = 1.
- Output holding
  - While ValidM = 1 and ReadyM = 0, all M outputs hold stable.
- Control gating
  - PCSrcM, MemtoRegM and MemWriteM = stored bit & ValidM.
  - RegWriteM = stored RegWriteE & ValidM & (|LaneMaskM).
  - MemWriteM is not mask-gated; Memory applies LaneMaskM per lane.
- Flush
  - FlushE = 1 at a clock edge forces state to EMPTY and clears the stored control bits of OUT and SKD.
  - Flush overrides a same-cycle accept and drain: the input is not captured.
  - Data, mask and WA3 contents are held, not cleared.
  - ReadyE = 1 in the cycle after flush.
- Reset
  - RST asserts state EMPTY asynchronously, including mid-transfer.
  - All OUT/SKD fields go to 0, so every M output is 0 and ValidM = 0.
  - ReadyE = 1 and Occupancy = 0 while RST is high and after release.
  - The first accept is possible at the first rising edge after deassertion.

Test Plan:
- Reset: RST pulsed between edges with FULL occupancy → immediately ValidM = 0, ReadyE = 1, Occupancy = 0, all M outputs 0.
- Streaming: ReadyM = 1; send bundles WA3 = 1,2,3,4 with lane0 ALUResult = 0x11,0x22,0x33,0x44 on consecutive cycles → each appears on M one cycle later, back-to-back, Occupancy never exceeds 1.
- Backpressure: ReadyM = 0; send WA3 = 5,6,7 → 5 and 6 accepted, ReadyE = 0 after second accept, 7 held by source. Raise ReadyM → M shows 5, 6, 7 in order, no loss or duplication.
- Flush in FULL: ValidE = 1 with WA3 = 9 and FlushE = 1 → next cycle ValidM = 0, all control outputs 0, Occupancy = 0. Bundle 9 never appears on M.
- Mask gating: RegWriteE = 1, LaneMaskE = 0x0000 → ValidM = 1, RegWriteM = 0. Same bundle with LaneMaskE = 0x8001 → RegWriteM = 1, LaneMaskM = 0x8001.
- Simultaneous accept/drain in ONE: ReadyM = 1 and a new bundle every cycle for 8 cycles → Occupancy stays 1 and ReadyE stays 1 throughout.

Source files
------------

// File: rtl/vec_pipe_stage_em_if.sv
// EX/MEM bundle interface: Execute-side inputs, Memory-side outputs, flush and occupancy.
interface vec_pipe_stage_em_if #(
   parameter int LANES = 16,
   parameter int DW    = 32,
   parameter int RAW   = 4
);
   logic                  FlushE;
   logic                  ValidE;
   logic                  ReadyE;
   logic [LANES*DW-1:0]   ALUResultE;
   logic [LANES*DW-1:0]   WriteDataE;
   logic [LANES-1:0]      LaneMaskE;
   logic                  PCSrcE;
   logic                  RegWriteE;
   logic                  MemtoRegE;
   logic                  MemWriteE;
   logic [RAW-1:0]        WA3E;

   logic                  ValidM;
   logic                  ReadyM;
   logic [LANES*DW-1:0]   ALUResultM;
   logic [LANES*DW-1:0]   WriteDataM;
   logic [LANES-1:0]      LaneMaskM;
   logic                  PCSrcM;
   logic                  RegWriteM;
   logic                  MemtoRegM;
   logic                  MemWriteM;
   logic [RAW-1:0]        WA3M;
   logic [1:0]            Occupancy;

   // Environment side: drives Execute bundle and Memory ready
   modport master (
      output FlushE, ValidE, ALUResultE, WriteDataE, LaneMaskE,
             PCSrcE, RegWriteE, MemtoRegE, MemWriteE, WA3E, ReadyM,
      input  ReadyE, ValidM, ALUResultM, WriteDataM, LaneMaskM,
             PCSrcM, RegWriteM, MemtoRegM, MemWriteM, WA3M, Occupancy
   );

   // Pipeline stage side
   modport slave (
      input  FlushE, ValidE, ALUResultE, WriteDataE, LaneMaskE,
             PCSrcE, RegWriteE, MemtoRegE, MemWriteE, WA3E, ReadyM,
      output ReadyE, ValidM, ALUResultM, WriteDataM, LaneMaskM,
             PCSrcM, RegWriteM, MemtoRegM, MemWriteM, WA3M, Occupancy
   );
endinterface

// File: rtl/vec_pipe_stage_em.sv
// EX/MEM vector pipeline stage with a 2-entry skid buffer (OUT + SKD).
// ReadyE comes straight from the state register, so Memory stalls never
// create a combinational path back into Execute.
module vec_pipe_stage_em #(
   parameter int LANES = 16,
   parameter int DW    = 32,
   parameter int RAW   = 4
) (
   input  logic CLK,
   input  logic RST,
   vec_pipe_stage_em_if.slave bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t stateReg, stateNext;

   logic readyE, validM;
   logic accept, drain;
   logic loadOutIn, loadOutSkd, loadSkdIn;

   // Control bits packed as {PCSrc, RegWrite, MemtoReg, MemWrite}
   logic [3:0]        ctrlIn;
   logic [3:0]        outCtrlReg, skdCtrlReg;
   logic [LANES-1:0]  outMaskReg, skdMaskReg;
   logic [RAW-1:0]    outWa3Reg,  skdWa3Reg;

   assign readyE = (stateReg != FULL);
   assign validM = (stateReg != EMPTY);
   assign accept = bus.ValidE & readyE;
   assign drain  = validM & bus.ReadyM;
   assign ctrlIn = {bus.PCSrcE, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE};

   // State register; reset forces EMPTY at once, even mid-transfer
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) stateReg <= EMPTY;
      else     stateReg <= stateNext;
   end

   // Next state and load strobes; flush wins over any same-cycle transfer
   always_comb begin
      stateNext  = stateReg;
      loadOutIn  = 1'b0;
      loadOutSkd = 1'b0;
      loadSkdIn  = 1'b0;
      if (bus.FlushE) begin
         stateNext = EMPTY;
      end else begin
         case (stateReg)
            EMPTY: begin
               if (accept) begin
                  loadOutIn = 1'b1;
                  stateNext = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  loadOutIn = 1'b1;
               end else if (accept) begin
                  loadSkdIn = 1'b1;
                  stateNext = FULL;
               end else if (drain) begin
                  stateNext = EMPTY;
               end
            end
            FULL: begin
               // accept is impossible here because readyE is low
               if (drain) begin
                  loadOutSkd = 1'b1;
                  stateNext  = ONE;
               end
            end
            default: stateNext = EMPTY;
         endcase
      end
   end

   // Control bits: cleared by flush so a stale entry can never re-assert them
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         outCtrlReg <= '0;
         skdCtrlReg <= '0;
      end else if (bus.FlushE) begin
         outCtrlReg <= '0;
         skdCtrlReg <= '0;
      end else begin
         if (loadOutIn)       outCtrlReg <= ctrlIn;
         else if (loadOutSkd) outCtrlReg <= skdCtrlReg;
         if (loadSkdIn)       skdCtrlReg <= ctrlIn;
      end
   end

   // Mask and destination register: held (not cleared) across a flush
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         outMaskReg <= '0;
         skdMaskReg <= '0;
         outWa3Reg  <= '0;
         skdWa3Reg  <= '0;
      end else begin
         if (loadOutIn) begin
            outMaskReg <= bus.LaneMaskE;
            outWa3Reg  <= bus.WA3E;
         end else if (loadOutSkd) begin
            outMaskReg <= skdMaskReg;
            outWa3Reg  <= skdWa3Reg;
         end
         if (loadSkdIn) begin
            skdMaskReg <= bus.LaneMaskE;
            skdWa3Reg  <= bus.WA3E;
         end
      end
   end

   // Per-lane data storage; each lane is an independent OUT/SKD pair
   for (genvar gi = 0; gi < LANES; gi++) begin : gLane
      logic [DW-1:0] outAluReg, skdAluReg;
      logic [DW-1:0] outWdReg,  skdWdReg;

      // Lane data registers follow the same load strobes as the control path
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            outAluReg <= '0;
            skdAluReg <= '0;
            outWdReg  <= '0;
            skdWdReg  <= '0;
         end else begin
            if (loadOutIn) begin
               outAluReg <= bus.ALUResultE[gi*DW +: DW];
               outWdReg  <= bus.WriteDataE[gi*DW +: DW];
            end else if (loadOutSkd) begin
               outAluReg <= skdAluReg;
               outWdReg  <= skdWdReg;
            end
            if (loadSkdIn) begin
               skdAluReg <= bus.ALUResultE[gi*DW +: DW];
               skdWdReg  <= bus.WriteDataE[gi*DW +: DW];
            end
         end
      end

      assign bus.ALUResultM[gi*DW +: DW] = outAluReg;
      assign bus.WriteDataM[gi*DW +: DW] = outWdReg;
   end

   assign bus.ReadyE    = readyE;
   assign bus.ValidM    = validM;
   assign bus.Occupancy = stateReg;
   assign bus.LaneMaskM = outMaskReg;
   assign bus.WA3M      = outWa3Reg;

   // Controls only assert for a live bundle; RegWrite also needs at least one lane.
   // MemWrite is left unmasked: Memory applies LaneMaskM per lane itself.
   assign bus.PCSrcM    = outCtrlReg[3] & validM;
   assign bus.RegWriteM = outCtrlReg[2] & validM & (|outMaskReg);
   assign bus.MemtoRegM = outCtrlReg[1] & validM;
   assign bus.MemWriteM = outCtrlReg[0] & validM;

endmodule

// File: tb/tb_vec_pipe_stage_em.sv
// Directed testbench for vec_pipe_stage_em: reset, streaming, backpressure,
// flush, mask gating and sustained accept/drain.
module tb_vec_pipe_stage_em;
   localparam int LANES = 16;
   localparam int DW    = 32;
   localparam int RAW   = 4;
   localparam int VW    = LANES*DW;

   logic CLK;
   logic RST;
   int   nAssert;
   int   nFail;

   vec_pipe_stage_em_if #(.LANES(LANES), .DW(DW), .RAW(RAW)) bus ();

   vec_pipe_stage_em #(.LANES(LANES), .DW(DW), .RAW(RAW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Lane i of a bundle tagged val carries val + i*0x100
   function automatic logic [VW-1:0] aluVec(input logic [7:0] val);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < LANES; i++) v[i*DW +: DW] = 32'(val) + 32'(i*256);
      return v;
   endfunction

   function automatic logic [VW-1:0] wdVec(input logic [7:0] val);
      return ~aluVec(val);
   endfunction

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ctrl = {PCSrc, RegWrite, MemtoReg, MemWrite}
   task automatic drive(input logic v, input logic [RAW-1:0] wa, input logic [7:0] val,
                        input logic [LANES-1:0] mask, input logic [3:0] ctrl);
      bus.ValidE     = v;
      bus.WA3E       = wa;
      bus.ALUResultE = aluVec(val);
      bus.WriteDataE = wdVec(val);
      bus.LaneMaskE  = mask;
      {bus.PCSrcE, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE} = ctrl;
   endtask

   // Full check of the M-side bundle; ctrl is the expected gated control nibble
   task automatic chkBundle(input string tag, input logic [RAW-1:0] wa, input logic [7:0] val,
                            input logic [LANES-1:0] mask, input logic [3:0] ctrl);
      chk({tag, ".valid"}, VW'(bus.ValidM), VW'(1'b1));
      chk({tag, ".wa3"},   VW'(bus.WA3M), VW'(wa));
      chk({tag, ".alu"},   bus.ALUResultM, aluVec(val));
      chk({tag, ".wd"},    bus.WriteDataM, wdVec(val));
      chk({tag, ".mask"},  VW'(bus.LaneMaskM), VW'(mask));
      chk({tag, ".ctrl"},  VW'({bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}), VW'(ctrl));
   endtask

   task automatic chkIdle(input string tag);
      chk({tag, ".valid"}, VW'(bus.ValidM), VW'(1'b0));
      chk({tag, ".ready"}, VW'(bus.ReadyE), VW'(1'b1));
      chk({tag, ".occ"},   VW'(bus.Occupancy), VW'(2'd0));
      chk({tag, ".ctrl"},  VW'({bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}), VW'(4'b0000));
   endtask

   task automatic chkZeroOut(input string tag);
      chkIdle(tag);
      chk({tag, ".alu0"},  bus.ALUResultM, '0);
      chk({tag, ".wd0"},   bus.WriteDataM, '0);
      chk({tag, ".mask0"}, VW'(bus.LaneMaskM), VW'(0));
      chk({tag, ".wa30"},  VW'(bus.WA3M), VW'(0));
   endtask

   initial begin
      nAssert = 0;
      nFail   = 0;
      RST     = 1'b0;
      bus.FlushE = 1'b0;
      bus.ReadyM = 1'b0;
      drive(1'b0, '0, 8'h00, '0, 4'b0000);

      // ---- power-on reset ----
      #1 RST = 1'b1;
      #2;
      chkZeroOut("por");
      $display("step por: reset asserted, outputs cleared");
      tick();
      RST = 1'b0;

      // ---- streaming, ReadyM = 1 ----
      bus.ReadyM = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, RAW'(k), 8'(k*8'h11), 16'hFFFF, {3'b010, 1'(k % 2)});
         tick();
         chkBundle($sformatf("stream%0d", k), RAW'(k), 8'(k*8'h11), 16'hFFFF, {3'b010, 1'(k % 2)});
         chk($sformatf("stream%0d.occ", k), VW'(bus.Occupancy), VW'(2'd1));
         chk($sformatf("stream%0d.ready", k), VW'(bus.ReadyE), VW'(1'b1));
         $display("step stream %0d: WA3M=%0d occ=%0d", k, bus.WA3M, bus.Occupancy);
      end
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();
      chkIdle("streamEnd");

      // ---- backpressure ----
      bus.ReadyM = 1'b0;
      drive(1'b1, 4'd5, 8'h55, 16'h0F0F, 4'b1010);
      tick();
      chkBundle("bp5", 4'd5, 8'h55, 16'h0F0F, 4'b1010);
      chk("bp5.ready", VW'(bus.ReadyE), VW'(1'b1));
      drive(1'b1, 4'd6, 8'h66, 16'h00F0, 4'b0101);
      tick();
      chk("bp6.occ", VW'(bus.Occupancy), VW'(2'd2));
      chk("bp6.ready", VW'(bus.ReadyE), VW'(1'b0));
      chkBundle("bp6.hold", 4'd5, 8'h55, 16'h0F0F, 4'b1010);
      drive(1'b1, 4'd7, 8'h77, 16'h0001, 4'b0100);
      tick();
      chk("bp7.occ", VW'(bus.Occupancy), VW'(2'd2));
      chkBundle("bp7.hold", 4'd5, 8'h55, 16'h0F0F, 4'b1010);
      $display("step backpressure: full, WA3M=%0d held", bus.WA3M);
      bus.ReadyM = 1'b1;
      tick();
      chkBundle("bpOut6", 4'd6, 8'h66, 16'h00F0, 4'b0101);
      chk("bpOut6.occ", VW'(bus.Occupancy), VW'(2'd1));
      chk("bpOut6.ready", VW'(bus.ReadyE), VW'(1'b1));
      tick();
      chkBundle("bpOut7", 4'd7, 8'h77, 16'h0001, 4'b0100);
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();
      chkIdle("bpEnd");
      $display("step backpressure: drained 5,6,7");

      // ---- flush while FULL ----
      bus.ReadyM = 1'b0;
      drive(1'b1, 4'd10, 8'hA0, 16'hFFFF, 4'b1111);
      tick();
      drive(1'b1, 4'd11, 8'hB0, 16'hFFFF, 4'b1111);
      tick();
      chk("flPre.occ", VW'(bus.Occupancy), VW'(2'd2));
      chkBundle("flPre", 4'd10, 8'hA0, 16'hFFFF, 4'b1111);
      bus.FlushE = 1'b1;
      bus.ReadyM = 1'b1;
      drive(1'b1, 4'd9, 8'h99, 16'hFFFF, 4'b1111);
      tick();
      bus.FlushE = 1'b0;
      chkIdle("flush");
      chk("flush.wa3Held", VW'(bus.WA3M), VW'(4'd10));
      chk("flush.aluHeld", bus.ALUResultM, aluVec(8'hA0));
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();
      chkIdle("flushAfter");
      $display("step flush: occ=%0d validM=%0d", bus.Occupancy, bus.ValidM);

      // ---- mask gating ----
      bus.ReadyM = 1'b0;
      drive(1'b1, 4'd3, 8'h30, 16'h0000, 4'b0100);
      tick();
      chkBundle("mask0", 4'd3, 8'h30, 16'h0000, 4'b0000);
      bus.ReadyM = 1'b1;
      drive(1'b1, 4'd3, 8'h30, 16'h8001, 4'b0100);
      tick();
      chkBundle("mask8001", 4'd3, 8'h30, 16'h8001, 4'b0100);
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();
      chkIdle("maskEnd");
      $display("step mask gating done");

      // ---- sustained accept/drain in ONE ----
      bus.ReadyM = 1'b1;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, RAW'(k + 8), 8'(8'hC0 + k), 16'h1234, 4'b0010);
         tick();
         chkBundle($sformatf("sus%0d", k), RAW'(k + 8), 8'(8'hC0 + k), 16'h1234, 4'b0010);
         chk($sformatf("sus%0d.occ", k), VW'(bus.Occupancy), VW'(2'd1));
         chk($sformatf("sus%0d.ready", k), VW'(bus.ReadyE), VW'(1'b1));
         $display("step sustain %0d: WA3M=%0d occ=%0d", k, bus.WA3M, bus.Occupancy);
      end
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();
      chkIdle("susEnd");

      // ---- asynchronous reset while FULL ----
      bus.ReadyM = 1'b0;
      drive(1'b1, 4'd13, 8'hD0, 16'hFFFF, 4'b1111);
      tick();
      drive(1'b1, 4'd14, 8'hE0, 16'hFFFF, 4'b1111);
      tick();
      chk("rstPre.occ", VW'(bus.Occupancy), VW'(2'd2));
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      #2 RST = 1'b1;
      #1;
      chkZeroOut("rstMid");
      tick();
      chkZeroOut("rstHeld");
      RST = 1'b0;
      bus.ReadyM = 1'b1;
      drive(1'b1, 4'd15, 8'hF0, 16'h0003, 4'b0110);
      tick();
      chkBundle("rstFirst", 4'd15, 8'hF0, 16'h0003, 4'b0110);
      chk("rstFirst.occ", VW'(bus.Occupancy), VW'(2'd1));
      $display("step reset: mid-transfer reset, first accept WA3M=%0d", bus.WA3M);
      drive(1'b0, '0, 8'h00, '0, 4'b0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   // Absolute bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: observed no completion expected completion");
      $fatal(1, "timeout");
   end
endmodule
